// File: rtl/median_window_gen.sv
// Raster-to-3x3-window front end: two shift-register line buffers feeding nine registered taps.
// Optional build macro MEDIAN_WIN_EDGE_ZERO_EN forces taps outside the frame to zero.
module median_window_gen #(
  parameter int ROW = 430,
  parameter int COL = 554
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic signed [31:0] pixel,
  output logic [7:0]         data_out_0,
  output logic [7:0]         data_out_1,
  output logic [7:0]         data_out_2,
  output logic [7:0]         data_out_3,
  output logic [7:0]         data_out_4,
  output logic [7:0]         data_out_5,
  output logic [7:0]         data_out_6,
  output logic [7:0]         data_out_7,
  output logic [7:0]         data_out_8,
  output logic               frame_done
);

  localparam int DEPTH = 2 * ROW;
  localparam int RW    = $clog2(ROW + 1);
  localparam int CW    = $clog2(COL + 1);
  localparam logic [RW-1:0] R_LAST  = RW'(ROW - 1);
  localparam logic [RW-1:0] R_FLUSH = RW'(ROW);
  localparam logic [CW-1:0] C_LAST  = CW'(COL - 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t             state_r, state_s;
  logic [RW-1:0]      in_r_r, in_r_s;
  logic [CW-1:0]      in_c_r, in_c_s;
  logic [RW-1:0]      win_r_r, win_r_s;
  logic [CW-1:0]      win_c_r, win_c_s;
  logic signed [31:0] win_idx_r, win_idx_s;
  logic [RW-1:0]      flush_cnt_r, flush_cnt_s;
  logic               in_ready_r, in_ready_s;
  logic               out_valid_r, frame_done_r;
  logic signed [31:0] pixel_r;
  logic [7:0]         dout_r [9];

  logic [7:0]         line_r [DEPTH];
  logic [7:0]         h1_r [3];
  logic [7:0]         h2_r [3];
  logic [7:0]         tap_s [3];
  logic [7:0]         win_s [9];

  logic accept_s, shift_s, emit_s, last_in_s, flush_last_s;

  // Handshake qualifiers for the current cycle
  always_comb begin
    accept_s     = in_valid & in_ready_r;
    shift_s      = accept_s | (state_r == FLUSH);
    emit_s       = (accept_s & (state_r == RUN)) | (state_r == FLUSH);
    last_in_s    = accept_s & (in_r_r == R_LAST) & (in_c_r == C_LAST);
    flush_last_s = (state_r == FLUSH) & (flush_cnt_r == R_FLUSH);
  end

  // Vertical taps: newest sample (line c+1), one line back (c), two lines back (c-1)
  always_comb begin
    tap_s[2] = accept_s ? in_data : 8'd0;
    tap_s[1] = line_r[ROW-1];
    tap_s[0] = line_r[DEPTH-1];
  end

  // Next window: column r+1 comes straight from the taps, r and r-1 from the horizontal shifts
  always_comb begin
    logic [7:0] raw;
    raw = 8'd0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        raw = (k == 2) ? tap_s[j] : ((k == 1) ? h1_r[j] : h2_r[j]);
`ifdef MEDIAN_WIN_EDGE_ZERO_EN
        if (((k == 0) && (win_r_r == '0)) || ((k == 2) && (win_r_r == R_LAST)) ||
            ((j == 0) && (win_c_r == '0)) || ((j == 2) && (win_c_r == C_LAST)))
          win_s[3*k+j] = 8'd0;
        else
          win_s[3*k+j] = raw;
`else
        win_s[3*k+j] = raw;
`endif
      end
    end
  end

  // FSM next state plus input, window and flush counters
  always_comb begin
    state_s     = state_r;
    in_ready_s  = in_ready_r;
    flush_cnt_s = flush_cnt_r;
    win_idx_s   = emit_s ? (win_idx_r + 32'sd1) : win_idx_r;

    if (accept_s) begin
      in_r_s = (in_r_r == R_LAST) ? '0 : (in_r_r + 1'b1);
      in_c_s = (in_r_r != R_LAST) ? in_c_r : ((in_c_r == C_LAST) ? '0 : (in_c_r + 1'b1));
    end else begin
      in_r_s = in_r_r;
      in_c_s = in_c_r;
    end

    if (emit_s) begin
      win_r_s = (win_r_r == R_LAST) ? '0 : (win_r_r + 1'b1);
      win_c_s = (win_r_r != R_LAST) ? win_c_r : ((win_c_r == C_LAST) ? '0 : (win_c_r + 1'b1));
    end else begin
      win_r_s = win_r_r;
      win_c_s = win_c_r;
    end

    case (state_r)
      FILL: begin
        // the first window needs sample ROW+1, so RUN starts after sample ROW
        if (accept_s && (in_r_r == '0) && (in_c_r == C_ONE))
          state_s = RUN;
        else
          state_s = FILL;
      end
      RUN: begin
        if (last_in_s) begin
          state_s     = FLUSH;
          in_ready_s  = 1'b0;
          flush_cnt_s = '0;
        end else begin
          state_s = RUN;
        end
      end
      FLUSH: begin
        if (flush_last_s) begin
          state_s     = FILL;
          in_ready_s  = 1'b1;
          flush_cnt_s = '0;
          in_r_s      = '0;
          in_c_s      = '0;
          win_r_s     = '0;
          win_c_s     = '0;
          win_idx_s   = 32'sd0;
        end else begin
          flush_cnt_s = flush_cnt_r + 1'b1;
        end
      end
      default: begin
        state_s    = FILL;
        in_ready_s = 1'b1;
      end
    endcase
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= FILL;
      in_r_r       <= '0;
      in_c_r       <= '0;
      win_r_r      <= '0;
      win_c_r      <= '0;
      win_idx_r    <= 32'sd0;
      flush_cnt_r  <= '0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      pixel_r      <= 32'sd0;
      dout_r       <= '{default: 8'd0};
    end else begin
      state_r      <= state_s;
      in_r_r       <= in_r_s;
      in_c_r       <= in_c_s;
      win_r_r      <= win_r_s;
      win_c_r      <= win_c_s;
      win_idx_r    <= win_idx_s;
      flush_cnt_r  <= flush_cnt_s;
      in_ready_r   <= in_ready_s;
      out_valid_r  <= emit_s;
      frame_done_r <= flush_last_s;
      if (emit_s) begin
        pixel_r <= win_idx_r;
        dout_r  <= win_s;
      end
    end
  end

  // Line buffers and horizontal shifts; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (shift_s) begin
      line_r[0] <= tap_s[2];
      for (int i = 1; i < DEPTH; i++) line_r[i] <= line_r[i-1];
      h2_r <= h1_r;
      h1_r <= tap_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign frame_done = frame_done_r;
  assign pixel      = pixel_r;
  assign data_out_0 = dout_r[0];
  assign data_out_1 = dout_r[1];
  assign data_out_2 = dout_r[2];
  assign data_out_3 = dout_r[3];
  assign data_out_4 = dout_r[4];
  assign data_out_5 = dout_r[5];
  assign data_out_6 = dout_r[6];
  assign data_out_7 = dout_r[7];
  assign data_out_8 = dout_r[8];

endmodule

// File: tb/tb_median_window_gen.sv
// Scoreboard bench for median_window_gen with ROW=4, COL=3 and in_data = sample index.
module tb_median_window_gen;

  localparam int ROW  = 4;
  localparam int COL  = 3;
  localparam int NPIX = ROW * COL;
`ifdef MEDIAN_WIN_EDGE_ZERO_EN
  localparam bit EDGE_ZERO = 1'b1;
`else
  localparam bit EDGE_ZERO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic in_ready, out_valid, frame_done;
  logic signed [31:0] pixel;
  logic [7:0] data_out_0, data_out_1, data_out_2, data_out_3, data_out_4;
  logic [7:0] data_out_5, data_out_6, data_out_7, data_out_8;
  logic [7:0] dout [9];

  median_window_gen #(.ROW(ROW), .COL(COL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .pixel(pixel),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .data_out_3(data_out_3), .data_out_4(data_out_4), .data_out_5(data_out_5),
    .data_out_6(data_out_6), .data_out_7(data_out_7), .data_out_8(data_out_8),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign dout[0] = data_out_0;
  assign dout[1] = data_out_1;
  assign dout[2] = data_out_2;
  assign dout[3] = data_out_3;
  assign dout[4] = data_out_4;
  assign dout[5] = data_out_5;
  assign dout[6] = data_out_6;
  assign dout[7] = data_out_7;
  assign dout[8] = data_out_8;

  typedef struct packed {
    logic [31:0] pix;
    logic [71:0] taps;
    logic [8:0]  care;
    logic        fd;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int win_cnt = 0;
  int fd_cnt = 0;
  bit edge_acc = 1'b0;
  bit edge_flush = 1'b0;

  // hand-computed windows; care masks mark the taps that lie inside the frame
  int hand0[9]  = '{0, 0, 0, 0, 0, 4, 0, 1, 5};
  int hand5[9]  = '{0, 4, 8, 1, 5, 9, 2, 6, 10};
  int hand11[9] = '{6, 10, 0, 7, 11, 0, 0, 0, 0};
  bit hc0[9]    = '{0, 0, 0, 0, 1, 1, 0, 1, 1};
  bit hc11[9]   = '{1, 1, 0, 1, 1, 0, 0, 0, 0};

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic exp_t model(input int p);
    exp_t e;
    int r, c, rr, cc;
    r = p % ROW;
    c = p / ROW;
    e.pix  = p;
    e.fd   = (p == NPIX - 1);
    e.taps = '0;
    e.care = '0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        rr = r + k - 1;
        cc = c + j - 1;
        if (rr >= 0 && rr < ROW && cc >= 0 && cc < COL) begin
          e.taps[8*(3*k+j) +: 8] = 8'(cc * ROW + rr);
          e.care[3*k+j] = 1'b1;
        end else begin
          e.care[3*k+j] = EDGE_ZERO;
        end
      end
    end
    return e;
  endfunction

  // Called just after a negedge; returns just after the negedge following acceptance
  task automatic send_sample(input int n, input int gap);
    int budget;
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = 8'(n);
    budget   = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout sample=%0d actual=0 required=1", n);
      in_valid = 1'b0;
      return;
    end
    if (n >= ROW + 1) exp_q.push_back(model(n - ROW - 1));
    if (n == NPIX - 1) begin
      for (int p = n - ROW; p <= n; p++) exp_q.push_back(model(p));
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input int gap);
    int low;
    for (int n = 0; n < NPIX; n++) send_sample(n, (n == 0) ? 0 : gap);
    low = 0;
    while (!in_ready && low < 20) begin
      low++;
      @(negedge clk);
    end
    chk("ready_low_cycles", low, ROW + 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_pixel"}, pixel, 0);
    for (int i = 0; i < 9; i++) chk($sformatf("%s_tap%0d", tag, i), dout[i], 0);
  endtask

  // Record what the DUT sees at each active edge (pre-update values)
  always @(posedge clk) begin
    edge_acc   = in_valid & in_ready;
    edge_flush = !in_ready;
  end

  // Monitor: pop and compare every presented window
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (frame_done && !out_valid) chk("frame_done_without_valid", frame_done, 0);
      if (out_valid) begin
        win_cnt++;
        chk("valid_cause", edge_acc | edge_flush, 1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_window pixel=%0d required=none", pixel);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", pixel, e.pix);
          chk($sformatf("frame_done_px%0d", e.pix), frame_done, e.fd);
          for (int i = 0; i < 9; i++) begin
            if (e.care[i]) chk($sformatf("tap%0d_px%0d", i, e.pix), dout[i], e.taps[8*i +: 8]);
          end
        end
        for (int i = 0; i < 9; i++) begin
          if (pixel == 0 && (EDGE_ZERO || hc0[i])) chk($sformatf("hand0_tap%0d", i), dout[i], hand0[i]);
          if (pixel == 5) chk($sformatf("hand5_tap%0d", i), dout[i], hand5[i]);
          if (pixel == 11 && (EDGE_ZERO || hc11[i])) chk($sformatf("hand11_tap%0d", i), dout[i], hand11[i]);
        end
        if (frame_done) begin
          fd_cnt++;
          chk("windows_per_frame", win_cnt, NPIX);
          win_cnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("in_reset");
    rst_n = 1'b1;
    #1;
    check_reset_values("after_reset");
    @(negedge clk);

    // continuous stream, then one sample every other cycle
    run_frame(0);
    run_frame(1);

    // reset in the middle of a frame, then a fresh frame
    for (int n = 0; n < 7; n++) send_sample(n, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("queue_before_reset", exp_q.size(), 0);
    rst_n = 1'b0;
    win_cnt = 0;
    #1;
    check_reset_values("mid_reset");
    exp_q.delete();
    @(negedge clk);
    chk("mid_reset_hold_valid", out_valid, 0);
    rst_n = 1'b1;
    run_frame(0);

    // back-to-back frames with in_valid never dropping
    run_frame(0);
    run_frame(0);

    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("frames_completed", fd_cnt, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
